// File: rtl/wb_commit_unit_if.sv
// MEM -> WB handshake plus register-file write port and status outputs.
// Latency: none, wires only.
// Backpressure: wb_ready from WB gates acceptance of mem_valid.
// Ports: mem_* and mem_rdata/_vld are driven by MEM; wb_ready, the
//        register-file write port (write_back_en/dest_wb/result_wb)
//        and the status outputs are driven by WB.
interface wb_commit_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) ();
    logic              mem_valid;
    logic              mem_wb_en;
    logic              mem_r_en;
    logic [ADDR_W-1:0] mem_dest;
    logic [DATA_W-1:0] mem_alu_res;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdata_vld;
    logic              wb_ready;
    logic              write_back_en;
    logic [ADDR_W-1:0] dest_wb;
    logic [DATA_W-1:0] result_wb;
    logic              illegal_dest;
    logic              load_timeout;
    logic [CNT_W-1:0]  retire_count;

    // MEM stage / register-file observer side
    modport master (
        output mem_valid, mem_wb_en, mem_r_en, mem_dest, mem_alu_res,
               mem_rdata, mem_rdata_vld,
        input  wb_ready, write_back_en, dest_wb, result_wb,
               illegal_dest, load_timeout, retire_count
    );

    // Write-back stage side
    modport slave (
        input  mem_valid, mem_wb_en, mem_r_en, mem_dest, mem_alu_res,
               mem_rdata, mem_rdata_vld,
        output wb_ready, write_back_en, dest_wb, result_wb,
               illegal_dest, load_timeout, retire_count
    );
endinterface

// File: rtl/wb_commit_unit.sv
// Write-back stage: retires one instruction per cycle, holding loads until data returns.
// Latency: non-load accepted at posedge N drives write_back_en from posedge N+1 to N+2.
// Backpressure: wb_ready drops while a load waits for memory data (bounded by LOAD_TIMEOUT).
// Ports: clk, rst (sync, active-high); bus (slave) carries the MEM handshake,
//        the registered register-file write port, illegal_dest / load_timeout
//        pulses and the retire_count counter.
module wb_commit_unit #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 4,
    parameter int NUM_REGS     = 15,
    parameter int LOAD_TIMEOUT = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    wb_commit_unit_if.slave  bus
);
    localparam int TW = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {EMPTY, WAIT_DATA, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     wait_cnt_q;
    logic              wb_en_q;
    logic [ADDR_W-1:0] dest_q;
    logic [DATA_W-1:0] result_q;

    logic              write_back_en_q;
    logic [ADDR_W-1:0] dest_wb_q;
    logic [DATA_W-1:0] result_wb_q;
    logic              illegal_dest_q;
    logic              load_timeout_q;
    logic [CNT_W-1:0]  retire_count_q;

    logic accept, take_entry, take_alu, take_rdata, to_timeout;
    logic dest_ok, do_write, do_illegal;

    assign bus.wb_ready = (state_q != WAIT_DATA);
    assign accept       = bus.mem_valid & bus.wb_ready;

    // Writes are resolved at the edge that closes the COMMIT cycle, so the
    // register file sees a stable port for the whole following cycle.
    assign dest_ok    = ({1'b0, dest_q} < NUM_REGS_W);
    assign do_write   = (state_q == COMMIT) & wb_en_q & dest_ok;
    assign do_illegal = (state_q == COMMIT) & wb_en_q & ~dest_ok;

    always_comb begin
        state_d    = state_q;
        take_entry = 1'b0;
        take_alu   = 1'b0;
        take_rdata = 1'b0;
        to_timeout = 1'b0;
        case (state_q)
            EMPTY, COMMIT: begin
                state_d = EMPTY;
                if (accept) begin
                    take_entry = 1'b1;
                    if (!bus.mem_r_en) begin
                        take_alu = 1'b1;
                        state_d  = COMMIT;
                    end else if (bus.mem_rdata_vld) begin
                        take_rdata = 1'b1;
                        state_d    = COMMIT;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                // Data arriving on the final wait cycle still wins over the timeout.
                if (bus.mem_rdata_vld) begin
                    take_rdata = 1'b1;
                    state_d    = COMMIT;
                end else if (wait_cnt_q == TW'(LOAD_TIMEOUT - 1)) begin
                    to_timeout = 1'b1;
                    state_d    = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= EMPTY;
            wait_cnt_q      <= '0;
            wb_en_q         <= 1'b0;
            dest_q          <= '0;
            result_q        <= '0;
            write_back_en_q <= 1'b0;
            dest_wb_q       <= '0;
            result_wb_q     <= '0;
            illegal_dest_q  <= 1'b0;
            load_timeout_q  <= 1'b0;
            retire_count_q  <= '0;
        end else begin
            state_q         <= state_d;
            write_back_en_q <= do_write;
            illegal_dest_q  <= do_illegal;
            load_timeout_q  <= to_timeout;
            if (state_q == COMMIT) begin
                dest_wb_q   <= dest_q;
                result_wb_q <= result_q;
            end
            if (do_write)
                retire_count_q <= retire_count_q + CNT_W'(1);
            if (take_entry) begin
                wb_en_q    <= bus.mem_wb_en;
                dest_q     <= bus.mem_dest;
                wait_cnt_q <= '0;
            end
            if (take_alu)
                result_q <= bus.mem_alu_res;
            if (take_rdata)
                result_q <= bus.mem_rdata;
            if (state_q == WAIT_DATA && !bus.mem_rdata_vld)
                wait_cnt_q <= wait_cnt_q + TW'(1);
        end
    end

    assign bus.write_back_en = write_back_en_q;
    assign bus.dest_wb       = dest_wb_q;
    assign bus.result_wb     = result_wb_q;
    assign bus.illegal_dest  = illegal_dest_q;
    assign bus.load_timeout  = load_timeout_q;
    assign bus.retire_count  = retire_count_q;
endmodule
